// File: rtl/rob_commit.sv
// rob_commit: 8-entry reorder buffer with in-order commit.
// Issue allocates entries at the tail and the CDB marks them complete.
// The head retires in program order to the register bank and the LSQ.
// A taken branch at commit flushes every younger entry.
module rob_commit #(
    parameter int DEPTH  = 8,
    parameter int IDX_W  = 3,
    parameter int DATA_W = 16,
    parameter int REG_W  = 4
) (
    input  logic              clk1,
    input  logic              rst_n,
    input  logic              alloc_valid,
    input  logic [REG_W-1:0]  alloc_func,
    input  logic [REG_W-1:0]  alloc_rd,
    output logic              alloc_ready,
    output logic [IDX_W-1:0]  alloc_idx,
    input  logic              wb_valid,
    input  logic [IDX_W-1:0]  wb_idx,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              wb_taken,
    output logic              commit_valid,
    input  logic              commit_ready,
    output logic [IDX_W-1:0]  commit_idx,
    output logic [REG_W-1:0]  commit_rd,
    output logic [DATA_W-1:0] commit_data,
    output logic              commit_we,
    output logic              commit_is_store,
    output logic              flush,
    output logic [REG_W-1:0]  flush_imm,
    output logic [IDX_W:0]    count,
    output logic              empty,
    output logic              full
);

    // Function codes: 0..4 write a register, 5 is a store, 6/7 are beq/bneq.
    localparam logic [REG_W-1:0] FUNC_LAST_WR = REG_W'(4);
    localparam logic [REG_W-1:0] FUNC_STORE   = REG_W'(5);
    localparam logic [REG_W-1:0] FUNC_BEQ     = REG_W'(6);
    localparam logic [REG_W-1:0] FUNC_BNEQ    = REG_W'(7);

    // Control state (reset).
    logic [DEPTH-1:0] busy;
    logic [DEPTH-1:0] done;
    logic [IDX_W-1:0] head_p;
    logic [IDX_W-1:0] tail_p;
    logic [IDX_W:0]   count_q;

    // Payload state (not reset).
    logic [DEPTH-1:0]  taken;
    logic [REG_W-1:0]  func_q [DEPTH];
    logic [REG_W-1:0]  rd_q   [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];

    logic alloc_fire;
    logic commit_fire;
    logic wb_hit;
    logic head_branch;

    // Handshakes, head decode and gated commit outputs.
    always_comb begin
        full            = (count_q == (IDX_W+1)'(DEPTH));
        empty           = (count_q == '0);
        count           = count_q;
        alloc_idx       = tail_p;
        commit_idx      = head_p;
        commit_valid    = busy[head_p] && done[head_p];
        commit_fire     = commit_valid && commit_ready;
        head_branch     = (func_q[head_p] == FUNC_BEQ) || (func_q[head_p] == FUNC_BNEQ);
        flush           = commit_fire && head_branch && taken[head_p];
        flush_imm       = flush ? rd_q[head_p] : '0;
        alloc_ready     = !full && !flush;
        alloc_fire      = alloc_valid && alloc_ready;
        // A writeback racing a flush is dropped along with everything else.
        wb_hit          = wb_valid && busy[wb_idx] && !flush;
        commit_rd       = commit_valid ? rd_q[head_p] : '0;
        commit_data     = commit_valid ? data_q[head_p] : '0;
        commit_we       = commit_valid && (func_q[head_p] <= FUNC_LAST_WR);
        commit_is_store = commit_valid && (func_q[head_p] == FUNC_STORE);
    end

    // Entry occupancy, pointers and the occupancy counter.
    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            busy    <= '0;
            done    <= '0;
            head_p  <= '0;
            tail_p  <= '0;
            count_q <= '0;
        end else if (flush) begin
            busy    <= '0;
            done    <= '0;
            head_p  <= '0;
            tail_p  <= '0;
            count_q <= '0;
        end else begin
            // NOTE: non-blocking assignments here, so every branch sees the
            // pre-edge head/tail/busy values regardless of statement order.
            if (alloc_fire) begin
                busy[tail_p] <= 1'b1;
                done[tail_p] <= 1'b0;
                tail_p       <= tail_p + IDX_W'(1);
            end
            if (wb_hit) begin
                done[wb_idx] <= 1'b1;
            end
            if (commit_fire) begin
                busy[head_p] <= 1'b0;
                head_p       <= head_p + IDX_W'(1);
            end
            case ({alloc_fire, commit_fire})
                2'b10:   count_q <= count_q + (IDX_W+1)'(1);
                2'b01:   count_q <= count_q - (IDX_W+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Entry payload: written on allocate and on writeback.
    // NOTE: the payload arrays carry no reset; every read is qualified by
    // busy/done, which are reset, so stale contents are never observed.
    always_ff @(posedge clk1) begin
        if (alloc_fire) begin
            func_q[tail_p] <= alloc_func;
            rd_q[tail_p]   <= alloc_rd;
            data_q[tail_p] <= '0;
            taken[tail_p]  <= 1'b0;
        end
        if (wb_hit) begin
            data_q[wb_idx] <= wb_data;
            taken[wb_idx]  <= wb_taken;
        end
    end

endmodule

// File: tb/tb_rob_commit.sv
// tb_rob_commit: directed stimulus for rob_commit with a commit scoreboard.
// Stimulus pushes each expected retirement into a queue; a monitor on the
// falling edge pops and compares whenever a commit handshake is presented.
module tb_rob_commit;

    logic        clk1 = 1'b0;
    logic        rst_n = 1'b0;
    logic        alloc_valid = 1'b0;
    logic [3:0]  alloc_func = '0;
    logic [3:0]  alloc_rd = '0;
    logic        alloc_ready;
    logic [2:0]  alloc_idx;
    logic        wb_valid = 1'b0;
    logic [2:0]  wb_idx = '0;
    logic [15:0] wb_data = '0;
    logic        wb_taken = 1'b0;
    logic        commit_valid;
    logic        commit_ready = 1'b1;
    logic [2:0]  commit_idx;
    logic [3:0]  commit_rd;
    logic [15:0] commit_data;
    logic        commit_we;
    logic        commit_is_store;
    logic        flush;
    logic [3:0]  flush_imm;
    logic [3:0]  count;
    logic        empty;
    logic        full;

    typedef struct packed {
        logic [2:0]  idx;
        logic [3:0]  rd;
        logic [15:0] data;
        logic        we;
        logic        st;
        logic        fl;
        logic [3:0]  fimm;
    } commit_t;

    commit_t exp_q[$];
    commit_t mon_got;
    commit_t mon_exp;
    int errors = 0;
    int checks = 0;

    rob_commit dut (
        .clk1            (clk1),
        .rst_n           (rst_n),
        .alloc_valid     (alloc_valid),
        .alloc_func      (alloc_func),
        .alloc_rd        (alloc_rd),
        .alloc_ready     (alloc_ready),
        .alloc_idx       (alloc_idx),
        .wb_valid        (wb_valid),
        .wb_idx          (wb_idx),
        .wb_data         (wb_data),
        .wb_taken        (wb_taken),
        .commit_valid    (commit_valid),
        .commit_ready    (commit_ready),
        .commit_idx      (commit_idx),
        .commit_rd       (commit_rd),
        .commit_data     (commit_data),
        .commit_we       (commit_we),
        .commit_is_store (commit_is_store),
        .flush           (flush),
        .flush_imm       (flush_imm),
        .count           (count),
        .empty           (empty),
        .full            (full)
    );

    always #5 clk1 = ~clk1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h required=%h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic commit_t mk(input logic [2:0] idx, input logic [3:0] rd,
                                   input logic [15:0] data, input logic we,
                                   input logic st, input logic fl, input logic [3:0] fimm);
        commit_t c;
        c.idx  = idx;
        c.rd   = rd;
        c.data = data;
        c.we   = we;
        c.st   = st;
        c.fl   = fl;
        c.fimm = fimm;
        return c;
    endfunction

    // Scoreboard monitor: compare every commit handshake against the queue head.
    always @(negedge clk1) begin
        if (rst_n && commit_valid && commit_ready) begin
            mon_got = '{commit_idx, commit_rd, commit_data, commit_we,
                        commit_is_store, flush, flush_imm};
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL commit_unexpected got=%h required=none at %0t", mon_got, $time);
            end else begin
                mon_exp = exp_q.pop_front();
                check("commit", 32'(mon_got), 32'(mon_exp));
            end
        end else if (rst_n) begin
            check("flush_idle", 32'(flush), 32'd0);
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk1);
        #1;
    endtask

    task automatic do_reset();
        check("sb_drained", 32'(exp_q.size()), 32'd0);
        rst_n        = 1'b0;
        alloc_valid  = 1'b0;
        wb_valid     = 1'b0;
        commit_ready = 1'b1;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic alloc(input logic [3:0] f, input logic [3:0] r);
        alloc_valid = 1'b1;
        alloc_func  = f;
        alloc_rd    = r;
        tick();
        alloc_valid = 1'b0;
    endtask

    task automatic wb(input logic [2:0] idx, input logic [15:0] data, input logic tk);
        wb_valid = 1'b1;
        wb_idx   = idx;
        wb_data  = data;
        wb_taken = tk;
        tick();
        wb_valid = 1'b0;
    endtask

    initial begin
        // Reset values while rst_n is low.
        #2;
        check("rst_alloc_ready", 32'(alloc_ready), 32'd1);
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_count", 32'(count), 32'd0);
        check("rst_commit_valid", 32'(commit_valid), 32'd0);
        check("rst_flush", 32'(flush), 32'd0);
        check("rst_alloc_idx", 32'(alloc_idx), 32'd0);
        @(posedge clk1);
        #1;
        rst_n = 1'b1;

        // First allocation and its retirement.
        check("t1_alloc_idx", 32'(alloc_idx), 32'd0);
        alloc(4'd0, 4'd3);
        check("t1_count", 32'(count), 32'd1);
        check("t1_alloc_idx_next", 32'(alloc_idx), 32'd1);
        exp_q.push_back(mk(3'd0, 4'd3, 16'h1234, 1'b1, 1'b0, 1'b0, 4'd0));
        wb(3'd0, 16'h1234, 1'b0);
        tick();
        check("t1_drained", 32'(count), 32'd0);

        // Out-of-order completion, in-order commit.
        do_reset();
        alloc(4'd0, 4'd2);
        alloc(4'd1, 4'd5);
        wb(3'd1, 16'h0007, 1'b0);
        check("t2_head_not_done", 32'(commit_valid), 32'd0);
        check("t2_count", 32'(count), 32'd2);
        exp_q.push_back(mk(3'd0, 4'd2, 16'h0011, 1'b1, 1'b0, 1'b0, 4'd0));
        exp_q.push_back(mk(3'd1, 4'd5, 16'h0007, 1'b1, 1'b0, 1'b0, 4'd0));
        wb(3'd0, 16'h0011, 1'b0);
        tick(2);
        check("t2_empty", 32'(empty), 32'd1);

        // Fill to full, ignored ninth alloc, commit at full, wrap.
        do_reset();
        for (int i = 0; i < 8; i++) alloc(4'd0, 4'(i));
        check("t3_full", 32'(full), 32'd1);
        check("t3_alloc_ready", 32'(alloc_ready), 32'd0);
        check("t3_count8", 32'(count), 32'd8);
        alloc(4'd0, 4'hF);
        check("t3_ninth_ignored", 32'(count), 32'd8);
        check("t3_tail_wrapped", 32'(alloc_idx), 32'd0);
        exp_q.push_back(mk(3'd0, 4'd0, 16'h00A0, 1'b1, 1'b0, 1'b0, 4'd0));
        wb(3'd0, 16'h00A0, 1'b0);
        check("t3_full_commit_valid", 32'(commit_valid), 32'd1);
        check("t3_full_commit_blocks_alloc", 32'(alloc_ready), 32'd0);
        tick();
        check("t3_count7", 32'(count), 32'd7);
        check("t3_ready_again", 32'(alloc_ready), 32'd1);
        check("t3_head1", 32'(commit_idx), 32'd1);
        alloc(4'd1, 4'd9);
        check("t3_refull", 32'(full), 32'd1);
        check("t3_tail_after_wrap", 32'(alloc_idx), 32'd1);

        // Store at head held by backpressure.
        do_reset();
        alloc(4'd5, 4'd4);
        commit_ready = 1'b0;
        wb(3'd0, 16'h0BEE, 1'b0);
        for (int i = 0; i < 3; i++) begin
            check("t4_valid", 32'(commit_valid), 32'd1);
            check("t4_is_store", 32'(commit_is_store), 32'd1);
            check("t4_we", 32'(commit_we), 32'd0);
            check("t4_head_hold", 32'(commit_idx), 32'd0);
            tick();
        end
        exp_q.push_back(mk(3'd0, 4'd4, 16'h0BEE, 1'b0, 1'b1, 1'b0, 4'd0));
        commit_ready = 1'b1;
        tick();
        check("t4_head_adv", 32'(commit_idx), 32'd1);
        check("t4_count", 32'(count), 32'd0);

        // Taken beq at head flushes three younger entries.
        do_reset();
        commit_ready = 1'b0;
        alloc(4'd6, 4'hA);
        alloc(4'd0, 4'd1);
        alloc(4'd0, 4'd2);
        alloc(4'd1, 4'd3);
        check("t5_count4", 32'(count), 32'd4);
        wb(3'd0, 16'h0001, 1'b1);
        check("t5_no_flush_unready", 32'(flush), 32'd0);
        exp_q.push_back(mk(3'd0, 4'hA, 16'h0001, 1'b0, 1'b0, 1'b1, 4'hA));
        commit_ready = 1'b1;
        alloc_valid  = 1'b1;
        alloc_func   = 4'd0;
        alloc_rd     = 4'd7;
        wb_valid     = 1'b1;
        wb_idx       = 3'd2;
        wb_data      = 16'h0055;
        wb_taken     = 1'b0;
        #1;
        check("t5_flush", 32'(flush), 32'd1);
        check("t5_flush_imm", 32'(flush_imm), 32'hA);
        check("t5_alloc_blocked", 32'(alloc_ready), 32'd0);
        tick();
        alloc_valid = 1'b0;
        wb_valid    = 1'b0;
        check("t5_count0", 32'(count), 32'd0);
        check("t5_empty", 32'(empty), 32'd1);
        check("t5_tail0", 32'(alloc_idx), 32'd0);
        check("t5_head0", 32'(commit_idx), 32'd0);
        wb(3'd2, 16'h0066, 1'b0);
        check("t5_stale_wb_valid", 32'(commit_valid), 32'd0);
        check("t5_stale_wb_count", 32'(count), 32'd0);
        alloc(4'd0, 4'd8);
        check("t5_new_alloc_count", 32'(count), 32'd1);
        check("t5_new_not_done", 32'(commit_valid), 32'd0);

        // Not-taken bneq commits normally without a register write.
        do_reset();
        alloc(4'd7, 4'd5);
        exp_q.push_back(mk(3'd0, 4'd5, 16'h0002, 1'b0, 1'b0, 1'b0, 4'd0));
        wb(3'd0, 16'h0002, 1'b0);
        tick();
        check("t6_count", 32'(count), 32'd0);

        // Asynchronous reset with five entries in flight.
        do_reset();
        commit_ready = 1'b0;
        for (int i = 0; i < 5; i++) alloc(4'd0, 4'(i + 1));
        wb(3'd0, 16'h0003, 1'b0);
        check("t7_pre_valid", 32'(commit_valid), 32'd1);
        check("t7_pre_count", 32'(count), 32'd5);
        #2;
        rst_n = 1'b0;
        #1;
        check("t7_count", 32'(count), 32'd0);
        check("t7_empty", 32'(empty), 32'd1);
        check("t7_full", 32'(full), 32'd0);
        check("t7_alloc_ready", 32'(alloc_ready), 32'd1);
        check("t7_alloc_idx", 32'(alloc_idx), 32'd0);
        check("t7_commit_valid", 32'(commit_valid), 32'd0);
        check("t7_commit_idx", 32'(commit_idx), 32'd0);
        check("t7_commit_rd", 32'(commit_rd), 32'd0);
        check("t7_commit_data", 32'(commit_data), 32'd0);
        check("t7_commit_we", 32'(commit_we), 32'd0);
        check("t7_flush_imm", 32'(flush_imm), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        check("t7_post_count", 32'(count), 32'd0);

        check("sb_final_drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
